usb_rx_line_decode: RTL and testbench
=====================================

# usb_rx_line_decode

Receive line front end for the USB host receive path, directly upstream of the DP/DM packet-decode FSM. It samples DP/DM once per bit-clock and classifies each sample as J, K, SE0 or SE1. It performs NRZI decoding, SYNC detection and bit unstuffing, and tracks EOP. It produces the `in_bit`/`sync_rec`/`se0_rec` strobes that the packet-decode FSM consumes.

## Interface
- `SYNC_TIMEOUT`, 32: max samples spent in HUNT before abort; legal range 8..255.
- `clock`  in  1  bit-rate clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset, no other clock domains.
- `DP_in`  in  1  sampled D+ (already synchronised).
- `DM_in`  in  1  sampled D−.
- `rec_start`  in  1  arm receiver; honoured only in IDLE.
- `in_bit`  out  1  decoded, unstuffed data bit; meaningful only when `bit_valid`=1.
- `bit_valid`  out  1  `in_bit` carries a payload bit (PID onward).
- `sync_rec`  out  1  one-cycle pulse: SYNC pattern completed.
- `se0_rec`  out  1  high for every SE0 sample seen in DATA or EOP.
- `eop_done`  out  1  one-cycle pulse: valid EOP (SE0, SE0, J) completed.
- `rx_err`  out  1  one-cycle pulse: abort (SE1, SYNC timeout, bad EOP, stuff error).

## Operation
- Line states: J = DP1/DM0, K = DP0/DM1, SE0 = 00, SE1 = 11.
- NRZI: `prev` register holds the last J/K state; reset value J.
  - Decoded bit = 1 if the current state equals `prev`, 0 otherwise.
  - `prev` updates on every J/K sample in every state; it holds on SE0/SE1.
- IDLE: all outputs 0. If `rec_start`=1, go to HUNT next cycle. The same-cycle sample only updates `prev`.
- HUNT: decoded bits shift into an 8-bit register `sr` at the LSB. `sr` clears on HUNT entry.
  - `sr`==8'b0000_0001 (seven 0s then a 1) → `sync_rec` pulse, go to DATA, set ones counter to 1.
  - Hunt counter increments per sample. When it reaches `SYNC_TIMEOUT` → `rx_err`, go to IDLE.
  - SE0 in HUNT is ignored and resets `sr`. SE1 → `rx_err`, go to IDLE.
- DATA: 3-bit ones counter.
  - Decoded 1 → counter++, emit bit.
  - Decoded 0 → counter=0, emit bit.
  - When counter==6, the next sample is a stuff bit. Decoded 0 is dropped (`bit_valid`=0) and the counter is cleared. Decoded 1 is handled per Configuration.
  - SE0 → `se0_rec`=1, go to EOP1, counter=0. SE1 → `rx_err`, go to IDLE.
- EOP1: SE0 → `se0_rec`=1, go to EOP2. J or K → `rx_err`, go to IDLE.
- EOP2: J → `eop_done`, go to IDLE. K, SE0 or SE1 → `rx_err`, go to IDLE.
- `rec_start` outside IDLE is ignored.
- Synchronous `reset` mid-packet clears all state at that edge:
  - state = IDLE, `prev` = J, `sr` = 0, all counters = 0, all outputs = 0.

## Timing
- All outputs are registered. Each reflects the sample taken one clock earlier (latency 1).
- All outputs reset to 0.
- `sync_rec` is asserted in the cycle after the final K of SYNC is sampled. The first PID bit's `bit_valid` follows one cycle after that.
- At most one of `sync_rec`, `eop_done`, `rx_err` is high in any cycle. `bit_valid` is never high with `se0_rec`.
- A stuffed-bit cycle produces exactly one `bit_valid`=0 gap.

## Configuration
- `USB_RX_STUFF_ERR_EN` defined: a decoded 1 in the stuff position triggers an `rx_err` pulse and a transition to IDLE. No bit is emitted.
- `USB_RX_STUFF_ERR_EN` undefined: the stuff-position bit is dropped regardless of value. The counter clears, no error is raised, and DATA continues.

## Test plan
- Reset, `rec_start`, line J then K J K J K J K K → `sync_rec` pulse one cycle after the last K; no `rx_err`.
- After SYNC, send the NRZI pattern for PID 8'b1101_0010 (LSB first) → eight `bit_valid` cycles; `in_bit` sequence 0,1,0,0,1,0,1,1.
- After SYNC, send data 1,1,1,1,1 (six ones counting the SYNC 1), then a stuff 0, then 1 → stuff cycle has `bit_valid`=0; data resumes with 1; ones count restarts.
- Same as above but the stuff bit is a 1 → with the macro: `rx_err` pulse and IDLE; without it: no error and the next bit is emitted.
- In DATA, send SE0, SE0, J → `se0_rec` high for 2 cycles, then `eop_done` pulse, then IDLE. Variant SE0, K → `rx_err`.
- `rec_start` with a constant J line → `rx_err` exactly `SYNC_TIMEOUT`=32 samples after entering HUNT. Assert `reset` mid-DATA → all outputs 0 on the next cycle and state IDLE.

Source files
------------

// File: rtl/usb_rx_line_decode.sv
// usb_rx_line_decode
//
// Receive line front end for the USB host receive path. It samples DP/DM once
// per bit clock and classifies each sample as J, K, SE0 or SE1. It then performs
// NRZI decoding, SYNC hunting, bit unstuffing and EOP tracking. The results are
// presented as registered strobes to the downstream packet-decode FSM.
//
// Optional feature macro: USB_RX_STUFF_ERR_EN
//   defined   : a decoded 1 in the stuff position aborts with rx_err.
//   undefined : the stuff-position bit is always dropped silently.
//
// Ports
//   clock      in   bit-rate clock, all logic on posedge
//   reset      in   synchronous, active-high
//   DP_in      in   sampled D+ (already synchronised)
//   DM_in      in   sampled D-
//   rec_start  in   arm receiver, honoured only in IDLE
//   in_bit     out  decoded, unstuffed data bit (qualified by bit_valid)
//   bit_valid  out  in_bit carries a payload bit
//   sync_rec   out  one-cycle pulse, SYNC completed
//   se0_rec    out  high for every SE0 sample seen in DATA or EOP
//   eop_done   out  one-cycle pulse, valid SE0 SE0 J completed
//   rx_err     out  one-cycle pulse, abort
//   state_dbg  out  current FSM state (0 IDLE, 1 HUNT, 2 DATA, 3 EOP1, 4 EOP2)
//
// All outputs are registered and reflect the sample taken one clock earlier.

module usb_rx_line_decode #(
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       DP_in,
    input  logic       DM_in,
    input  logic       rec_start,
    output logic       in_bit,
    output logic       bit_valid,
    output logic       sync_rec,
    output logic       se0_rec,
    output logic       eop_done,
    output logic       rx_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HUNT = 3'd1,
        S_DATA = 3'd2,
        S_EOP1 = 3'd3,
        S_EOP2 = 3'd4
    } state_t;

    state_t     state;
    logic       prev;      // last J/K line state, 1 = J
    logic [7:0] sr;        // HUNT shift register, newest bit at LSB
    logic [3:0] fill;      // bits shifted into sr since it was cleared, saturates at 8
    logic [7:0] hunt_cnt;  // samples spent in HUNT
    logic [2:0] ones;      // consecutive decoded ones in DATA

    logic       is_j;
    logic       is_k;
    logic       is_se0;
    logic       is_se1;
    logic       line_jk;
    logic       dec_bit;
    logic [7:0] sr_shift;
    logic [3:0] fill_inc;
    logic [7:0] hunt_inc;

    always_comb begin
        is_j     = DP_in & ~DM_in;
        is_k     = ~DP_in & DM_in;
        is_se0   = ~DP_in & ~DM_in;
        is_se1   = DP_in & DM_in;
        line_jk  = is_j | is_k;
        // NRZI: no transition decodes as 1
        dec_bit  = (is_j == prev);
        sr_shift = {sr[6:0], dec_bit};
        fill_inc = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
        hunt_inc = hunt_cnt + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            prev      <= 1'b1;
            sr        <= '0;
            fill      <= '0;
            hunt_cnt  <= '0;
            ones      <= '0;
            in_bit    <= 1'b0;
            bit_valid <= 1'b0;
            sync_rec  <= 1'b0;
            se0_rec   <= 1'b0;
            eop_done  <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            in_bit    <= 1'b0;
            bit_valid <= 1'b0;
            sync_rec  <= 1'b0;
            se0_rec   <= 1'b0;
            eop_done  <= 1'b0;
            rx_err    <= 1'b0;

            if (line_jk) begin
                prev <= is_j;
            end

            case (state)
                S_IDLE: begin
                    if (rec_start) begin
                        state    <= S_HUNT;
                        sr       <= '0;
                        fill     <= '0;
                        hunt_cnt <= '0;
                    end
                end

                S_HUNT: begin
                    hunt_cnt <= hunt_inc;
                    if (is_se1) begin
                        rx_err <= 1'b1;
                        state  <= S_IDLE;
                    end else if (line_jk && sr_shift == 8'b0000_0001 && fill_inc == 4'd8) begin
                        // The fill qualifier stops a freshly cleared sr from
                        // matching on its very first decoded 1.
                        sync_rec <= 1'b1;
                        ones     <= 3'd1;
                        state    <= S_DATA;
                    end else if (hunt_inc == 8'(SYNC_TIMEOUT)) begin
                        rx_err <= 1'b1;
                        state  <= S_IDLE;
                    end else if (is_se0) begin
                        sr   <= '0;
                        fill <= '0;
                    end else begin
                        sr   <= sr_shift;
                        fill <= fill_inc;
                    end
                end

                S_DATA: begin
                    if (is_se1) begin
                        rx_err <= 1'b1;
                        state  <= S_IDLE;
                    end else if (is_se0) begin
                        se0_rec <= 1'b1;
                        ones    <= '0;
                        state   <= S_EOP1;
                    end else if (ones == 3'd6) begin
                        // Stuff position: never emitted.
`ifdef USB_RX_STUFF_ERR_EN
                        if (dec_bit) begin
                            rx_err <= 1'b1;
                            state  <= S_IDLE;
                        end
`endif
                        ones <= '0;
                    end else begin
                        in_bit    <= dec_bit;
                        bit_valid <= 1'b1;
                        ones      <= dec_bit ? ones + 3'd1 : 3'd0;
                    end
                end

                S_EOP1: begin
                    if (is_se0) begin
                        se0_rec <= 1'b1;
                        state   <= S_EOP2;
                    end else begin
                        rx_err <= 1'b1;
                        state  <= S_IDLE;
                    end
                end

                S_EOP2: begin
                    if (is_j) begin
                        eop_done <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_usb_rx_line_decode.sv
// tb_usb_rx_line_decode
//
// Bench for usb_rx_line_decode. The stimulus side behaves as a USB transmitter.
// It NRZI-encodes payload bits against the last J/K level driven and inserts a
// stuff 0 after six consecutive ones. The decoder's output must therefore
// reproduce the payload exactly. Expected payload bits are held in exp_q and
// popped whenever the DUT reports bit_valid.
//
// Handshake: the decoder has no back-pressure. One symbol is driven per clock.
// Outputs are read on the following negedge and describe that symbol.

module tb_usb_rx_line_decode;

    localparam int SYNC_TIMEOUT = 32;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;
    localparam logic [1:0] SYNC_SYMS [9] = '{SYM_J, SYM_K, SYM_J, SYM_K, SYM_J,
                                             SYM_K, SYM_J, SYM_K, SYM_K};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    logic DP_in;
    logic DM_in;
    logic rec_start;
    logic in_bit;
    logic bit_valid;
    logic sync_rec;
    logic se0_rec;
    logic eop_done;
    logic rx_err;
    logic [2:0] state_dbg;

    always #5 clock = ~clock;

    usb_rx_line_decode #(.SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .DP_in     (DP_in),
        .DM_in     (DM_in),
        .rec_start (rec_start),
        .in_bit    (in_bit),
        .bit_valid (bit_valid),
        .sync_rec  (sync_rec),
        .se0_rec   (se0_rec),
        .eop_done  (eop_done),
        .rx_err    (rx_err),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];
    logic [0:0] pay_q[$];
    logic [1:0] tb_line;   // last J/K driven, i.e. the decoder's NRZI reference
    int ones;              // transmitter-side consecutive ones count

    logic o_bit, o_valid, o_sync, o_se0, o_eop, o_err;
    logic [2:0] o_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] sym, input logic rs);
        logic inv;
        {DP_in, DM_in} = sym;
        rec_start = rs;
        @(negedge clock);
        o_bit   = in_bit;
        o_valid = bit_valid;
        o_sync  = sync_rec;
        o_se0   = se0_rec;
        o_eop   = eop_done;
        o_err   = rx_err;
        o_state = state_dbg;
        if (sym == SYM_J || sym == SYM_K) tb_line = sym;
        inv = ((32'(o_sync) + 32'(o_eop) + 32'(o_err)) <= 32'd1) && !(o_valid && o_se0);
        chk("exclusive_strobes", 32'(inv), 32'd1);
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_bit", 32'(o_valid), 32'd0);
            else chk("payload_bit", 32'(o_bit), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic send_bit(input logic b, input logic rs);
        logic [1:0] sym;
        sym = b ? tb_line : ((tb_line == SYM_J) ? SYM_K : SYM_J);
        send(sym, rs);
    endtask

    // Arms the receiver, drives random HUNT noise (never seven zeros in a row),
    // then a SYNC (seven 0s and a 1). sync_rec must appear only on the final 1.
    task automatic hunt_to_sync(input int junk);
        int zrun;
        logic b;
        zrun = 0;
        send(SYM_J, 1'b1);
        chk("arm_quiet", 32'({o_sync, o_err, o_valid, o_se0}), 32'd0);
        for (int i = 0; i < junk; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                send(SYM_SE0, 1'b0);
                zrun = 0;
            end else begin
                b = ($urandom_range(0, 1) == 1);
                if (zrun >= 6) b = 1'b1;
                send_bit(b, 1'b0);
                zrun = b ? 0 : zrun + 1;
            end
            chk("hunt_noise_quiet", 32'({o_sync, o_err, o_valid, o_se0}), 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0, 1'b0);
            chk("sync_zeros_quiet", 32'({o_sync, o_err, o_valid}), 32'd0);
        end
        send_bit(1'b1, 1'b0);
        chk("sync_rec", 32'({o_sync, o_err, o_valid}), 32'd4);
        ones = 1;
    endtask

    task automatic send_payload();
        logic b;
        while (pay_q.size() > 0) begin
            b = pay_q.pop_front();
            exp_q.push_back(b);
            send_bit(b, 1'($urandom_range(0, 1)));
            chk("payload_valid", 32'(o_valid), 32'd1);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                send_bit(1'b0, 1'b0);
                chk("stuff_gap", 32'({o_valid, o_err}), 32'd0);
                ones = 0;
            end
        end
    endtask

    task automatic eop_good();
        send(SYM_SE0, 1'b0);
        chk("eop_se0_a", 32'({o_se0, o_valid, o_eop, o_err}), 32'd8);
        send(SYM_SE0, 1'b0);
        chk("eop_se0_b", 32'({o_se0, o_valid, o_eop, o_err}), 32'd8);
        send(SYM_J, 1'b0);
        chk("eop_done", 32'({o_se0, o_valid, o_eop, o_err}), 32'd2);
        chk("idle_after_eop", 32'(o_state), 32'd0);
    endtask

    task automatic rand_payload(input int n);
        for (int i = 0; i < n; i++) pay_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic idle_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            send(($urandom_range(0, 1) == 1) ? SYM_J : SYM_K, 1'b0);
            chk("idle_quiet", 32'({o_sync, o_err, o_valid, o_se0, o_eop}), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        {DP_in, DM_in} = SYM_J;
        rec_start = 1'b0;
        tb_line = SYM_J;
        ones = 0;

        // Reset state
        send(SYM_J, 1'b0);
        send(SYM_J, 1'b0);
        reset = 1'b0;
        chk("reset_outputs", 32'({in_bit, bit_valid, sync_rec, se0_rec, eop_done, rx_err}), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'd0);

        // SYNC without rec_start is ignored
        for (int i = 0; i < 9; i++) begin
            send(SYNC_SYMS[i], 1'b0);
            chk("idle_ignores_sync", 32'({o_sync, o_err, o_valid}), 32'd0);
        end

        // Literal SYNC J K J K J K J K K, then PID 8'b1101_0010
        send(SYM_J, 1'b1);
        for (int i = 0; i < 9; i++) begin
            send(SYNC_SYMS[i], 1'b0);
            chk("lit_sync_rec", 32'(o_sync), (i == 8) ? 32'd1 : 32'd0);
            chk("lit_sync_no_err", 32'(o_err), 32'd0);
        end
        ones = 1;
        begin
            logic [7:0] pid;
            pid = 8'b1101_0010;
            for (int i = 0; i < 8; i++) pay_q.push_back(pid[i]);
        end
        send_payload();
        eop_good();
        chk("pid_all_emitted", 32'(exp_q.size()), 32'd0);

        // Six ones (SYNC 1 + five) force a stuff 0, then data resumes
        hunt_to_sync(0);
        for (int i = 0; i < 6; i++) pay_q.push_back(1'b1);
        rand_payload(12);
        send_payload();
        eop_good();
        chk("stuff_all_emitted", 32'(exp_q.size()), 32'd0);

        // A 1 in the stuff position
        hunt_to_sync(3);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(1'b1);
            send_bit(1'b1, 1'b0);
            chk("pre_stuff_one", 32'(o_valid), 32'd1);
        end
        send_bit(1'b1, 1'b0);
`ifdef USB_RX_STUFF_ERR_EN
        chk("stuff1_err", 32'({o_valid, o_err}), 32'd1);
        chk("stuff1_idle", 32'(o_state), 32'd0);
`else
        chk("stuff1_drop", 32'({o_valid, o_err}), 32'd0);
        ones = 0;
        pay_q.push_back(1'b0);
        pay_q.push_back(1'b1);
        pay_q.push_back(1'b1);
        send_payload();
        eop_good();
`endif
        chk("stuff1_all_emitted", 32'(exp_q.size()), 32'd0);
        idle_quiet(2);

        // Random packets with random EOP endings
        for (int p = 0; p < 6; p++) begin
            int variant;
            hunt_to_sync($urandom_range(0, 12));
            rand_payload($urandom_range(8, 40));
            send_payload();
            variant = $urandom_range(0, 2);
            if (variant == 0) begin
                eop_good();
            end else if (variant == 1) begin
                send(SYM_SE0, 1'b0);
                chk("bad_eop1_se0", 32'({o_se0, o_err}), 32'd2);
                send(SYM_K, 1'b0);
                chk("bad_eop1_err", 32'({o_se0, o_eop, o_err}), 32'd1);
                chk("bad_eop1_idle", 32'(o_state), 32'd0);
            end else begin
                send(SYM_SE0, 1'b0);
                send(SYM_SE0, 1'b0);
                chk("bad_eop2_se0", 32'({o_se0, o_err}), 32'd2);
                send(SYM_SE1, 1'b0);
                chk("bad_eop2_err", 32'({o_se0, o_eop, o_err}), 32'd1);
            end
            chk("rand_all_emitted", 32'(exp_q.size()), 32'd0);
            idle_quiet(2);
        end

        // SE1 aborts in HUNT and in DATA
        send(SYM_J, 1'b1);
        send_bit(1'b0, 1'b0);
        send(SYM_SE1, 1'b0);
        chk("hunt_se1_err", 32'({o_err, o_sync}), 32'd2);
        chk("hunt_se1_idle", 32'(o_state), 32'd0);
        hunt_to_sync(1);
        rand_payload(5);
        send_payload();
        send(SYM_SE1, 1'b0);
        chk("data_se1_err", 32'({o_err, o_valid, o_se0}), 32'd4);
        chk("data_se1_idle", 32'(o_state), 32'd0);

        // SYNC timeout on a constant J line
        send(SYM_J, 1'b1);
        for (int i = 1; i <= SYNC_TIMEOUT; i++) begin
            send(SYM_J, 1'b0);
            if (i < SYNC_TIMEOUT) chk("timeout_not_yet", 32'({o_err, o_sync}), 32'd0);
            else chk("timeout_err", 32'({o_err, o_sync}), 32'd2);
        end
        chk("timeout_idle", 32'(o_state), 32'd0);

        // Reset in the middle of DATA
        hunt_to_sync(2);
        rand_payload(10);
        send_payload();
        reset = 1'b1;
        send_bit(1'b1, 1'b0);
        reset = 1'b0;
        tb_line = SYM_J;
        chk("midreset_outputs", 32'({o_bit, o_valid, o_sync, o_se0, o_eop, o_err}), 32'd0);
        chk("midreset_state", 32'(o_state), 32'd0);
        idle_quiet(3);
        hunt_to_sync(0);
        rand_payload(16);
        send_payload();
        eop_good();
        chk("final_all_emitted", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
